ad396x_spi_controller: RTL and testbench



---
 rtl/ad396x_pkg.sv | 44 ++++
 rtl/ad396x_spi_controller.sv | 167 ++++++++++++++++
 tb/tb_ad396x_spi_controller.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad396x_pkg.sv
// Shared definitions for the AD396x SPI configuration path: instruction field
// positions, register/instruction widths, controller state encoding and a
// helper that packs a single-byte register access into the 24-bit SPI word.
package ad396x_pkg;

  localparam int AD396X_REG_ADDR_W  = 10;
  localparam int AD396X_REG_DATA_W  = 8;
  localparam int AD396X_SPI_INSTR_W = 24;

  // Instruction word layout, MSB first on the wire.
  localparam int AD396X_INSTR_RW_BIT   = 23;
  localparam int AD396X_INSTR_LEN_MSB  = 22;
  localparam int AD396X_INSTR_LEN_LSB  = 18;
  localparam int AD396X_INSTR_ADDR_MSB = 17;
  localparam int AD396X_INSTR_ADDR_LSB = 8;
  localparam int AD396X_INSTR_DATA_MSB = 7;
  localparam int AD396X_INSTR_DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    RESP,
    GAP
  } ad396x_spi_state_t;

  // Length field stays zero: every access is a single byte. Reads carry a
  // zero data byte because the chip drives the data phase itself.
  function automatic logic [AD396X_SPI_INSTR_W-1:0] ad396x_build_instr(
    input logic                         wr,
    input logic [AD396X_REG_ADDR_W-1:0] addr,
    input logic [AD396X_REG_DATA_W-1:0] wdata
  );
    logic [AD396X_SPI_INSTR_W-1:0] w;
    w = '0;
    w[AD396X_INSTR_RW_BIT] = wr;
    w[AD396X_INSTR_LEN_MSB:AD396X_INSTR_LEN_LSB] = '0;
    w[AD396X_INSTR_ADDR_MSB:AD396X_INSTR_ADDR_LSB] = addr;
    w[AD396X_INSTR_DATA_MSB:AD396X_INSTR_DATA_LSB] = wr ? wdata : '0;
    return w;
  endfunction

endpackage

// File: rtl/ad396x_spi_controller.sv
// AD396x register-access SPI master: one 24-bit write/read instruction per
// command, read byte returned on a valid/ready response channel.
// Latency: rsp_valid 1+CS_SETUP+48*CLK_DIV+CS_HOLD cycles after accept.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready, then a
// GAP-cycle chip-select-high interval before the next command is taken.
// Ports: clk/rst (sync, active-high); cmd_* command channel; rsp_* response
// channel; busy; spi_csn/spi_clk/spi_mosi/spi_miso 4-wire SPI to the chip.
module ad396x_spi_controller
  import ad396x_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AD396X_REG_ADDR_W-1:0] cmd_addr,
  input  logic [AD396X_REG_DATA_W-1:0] cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [AD396X_REG_DATA_W-1:0] rsp_rdata,
  output logic                         busy,
  output logic                         spi_csn,
  output logic                         spi_clk,
  output logic                         spi_mosi,
  input  logic                         spi_miso
);

  localparam int HALF_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > GAP) ? CS_SETUP : GAP) :
                           ((CS_HOLD > GAP) ? CS_HOLD : GAP);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  // Timers count down to zero, so each is loaded with its length minus one.
  localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]  HOLD_LOAD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP - 1);
  localparam logic [4:0]        LAST_BIT   = 5'(AD396X_SPI_INSTR_W - 1);
  localparam logic [4:0]        DATA_BITS  = 5'(AD396X_REG_DATA_W);

  ad396x_spi_state_t               state;
  logic [AD396X_SPI_INSTR_W-1:0]   tx_sh;
  logic [AD396X_REG_DATA_W-1:0]    rx_sh;
  logic                            is_write;
  logic [TMR_W-1:0]                tmr;
  logic [HALF_W-1:0]               half_cnt;
  logic [4:0]                      bit_cnt;
  logic                            clk_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      spi_csn   <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      is_write  <= 1'b0;
      tmr       <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      clk_high  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tx_sh     <= ad396x_build_instr(cmd_write, cmd_addr, cmd_wdata);
            is_write  <= cmd_write;
            rx_sh     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            spi_csn   <= 1'b0;
            spi_clk   <= 1'b0;
            spi_mosi  <= cmd_write;  // instruction MSB is the R/W flag
            tmr       <= SETUP_LOAD;
            state     <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (tmr == '0) begin
            half_cnt <= HALF_LOAD;
            bit_cnt  <= LAST_BIT;
            clk_high <= 1'b0;
            state    <= SHIFT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        SHIFT: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - HALF_W'(1);
          end else if (!clk_high) begin
            spi_clk  <= 1'b1;
            clk_high <= 1'b1;
            half_cnt <= HALF_LOAD;
          end else begin
            // Last cycle of the high half: the chip has had a full half
            // period to settle MISO since the preceding falling edge.
            if (bit_cnt < DATA_BITS) begin
              rx_sh <= {rx_sh[AD396X_REG_DATA_W-2:0], spi_miso};
            end
            spi_clk  <= 1'b0;
            clk_high <= 1'b0;
            half_cnt <= HALF_LOAD;
            if (bit_cnt == '0) begin
              tmr   <= HOLD_LOAD;
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt - 5'd1;
              tx_sh    <= {tx_sh[AD396X_SPI_INSTR_W-2:0], 1'b0};
              spi_mosi <= tx_sh[AD396X_SPI_INSTR_W-2];
            end
          end
        end

        HOLD: begin
          if (tmr == '0) begin
            spi_csn   <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= is_write ? '0 : rx_sh;
            state     <= RESP;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            tmr       <= GAP_LOAD;
            state     <= ad396x_pkg::GAP;
          end
        end

        ad396x_pkg::GAP: begin
          if (tmr == '0) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad396x_spi_controller.sv
// Bench for ad396x_spi_controller: default-parameter instance exercised with
// directed writes/reads, backpressure, back-to-back and mid-shift reset, plus
// a minimum-timing instance (all timing parameters 1).
module tb_ad396x_spi_controller;

  localparam int P_CLK_DIV  = 4;
  localparam int P_CS_SETUP = 2;
  localparam int P_CS_HOLD  = 2;
  localparam int P_GAP      = 4;
  localparam int LOW_W      = P_CS_SETUP + 48 * P_CLK_DIV + P_CS_HOLD;  // 196
  localparam int LAT        = 1 + LOW_W;                                // 197

  `define CHK(tag, obs, want) \
    begin \
      checks++; \
      assert ((obs) === (want)) else begin \
        errors++; \
        $error("FAIL %s: observed %0h expected %0h", tag, (obs), (want)); \
      end \
    end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic busy, spi_csn, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;

  logic d2_rst;
  logic d2_cmd_valid, d2_cmd_ready, d2_cmd_write;
  logic [9:0] d2_cmd_addr;
  logic [7:0] d2_cmd_wdata;
  logic d2_rsp_valid, d2_rsp_ready;
  logic [7:0] d2_rsp_rdata;
  logic d2_busy, d2_spi_csn, d2_spi_clk, d2_spi_mosi;
  logic d2_spi_miso;

  ad396x_spi_controller #(
    .CLK_DIV(P_CLK_DIV), .CS_SETUP(P_CS_SETUP), .CS_HOLD(P_CS_HOLD), .GAP(P_GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  ad396x_spi_controller #(
    .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)
  ) dut2 (
    .clk(clk), .rst(d2_rst),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_write(d2_cmd_write),
    .cmd_addr(d2_cmd_addr), .cmd_wdata(d2_cmd_wdata),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_rdata(d2_rsp_rdata),
    .busy(d2_busy), .spi_csn(d2_spi_csn), .spi_clk(d2_spi_clk), .spi_mosi(d2_spi_mosi),
    .spi_miso(d2_spi_miso)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Scoreboard: expected response per accepted command.
  typedef struct {
    logic [23:0] word;
    logic [7:0]  rdata;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  logic [23:0] word_q[$];
  int width_q[$];

  logic [7:0] slave_byte = 8'h00;
  logic [23:0] mon_word = '0;
  int low_cnt = 0, high_cnt = 0, sl_idx = 0;
  int sclk_bad = 0, txn_cnt = 0, rsp_cnt = 0, rv_rise = 0, hs_cyc = 0;
  logic prev_sclk = 1'b0, prev_csn = 1'b1, prev_rv = 1'b0;

  // SPI slave model + monitor + response checker for the default instance.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_word = '0; low_cnt = 0; sl_idx = 0; spi_miso = 1'b0;
      high_cnt++;
    end else begin
      if (spi_clk !== prev_sclk && spi_csn === 1'b1) sclk_bad++;
      if (!spi_csn && prev_csn) begin
        txn_cnt++;
        `CHK("csn_high_gap", (high_cnt >= P_GAP), 1'b1)
        low_cnt = 0; mon_word = '0; sl_idx = 0; spi_miso = 1'b0;
      end
      if (spi_clk && !prev_sclk) mon_word = {mon_word[22:0], spi_mosi};
      if (!spi_clk && prev_sclk) begin
        sl_idx++;
        spi_miso = 1'b0;
        if (sl_idx >= 16 && sl_idx < 24) spi_miso = slave_byte[23 - sl_idx];
      end
      if (spi_csn && !prev_csn) begin
        word_q.push_back(mon_word);
        width_q.push_back(low_cnt);
        high_cnt = 0;
      end
      if (spi_csn) high_cnt++; else low_cnt++;
      if (rsp_valid && !prev_rv) rv_rise = cyc;
      if (rsp_valid && rsp_ready) begin
        exp_t e;
        hs_cyc = cyc;
        rsp_cnt++;
        `CHK("rsp_expected", (exp_q.size() > 0), 1'b1)
        `CHK("mosi_word_present", (word_q.size() > 0), 1'b1)
        if (exp_q.size() > 0 && word_q.size() > 0) begin
          e = exp_q.pop_front();
          `CHK("rsp_rdata", rsp_rdata, e.rdata)
          `CHK("rsp_latency", (rv_rise - e.acc), LAT)
          `CHK("mosi_word", word_q.pop_front(), e.word)
          `CHK("csn_low_width", width_q.pop_front(), LOW_W)
        end
      end
    end
    prev_sclk = spi_clk; prev_csn = spi_csn; prev_rv = rsp_valid;
  end

  // Monitor for the minimum-timing instance.
  logic [23:0] d2_word = '0;
  int d2_low = 0, d2_width = 0, d2_last_rise = -1, d2_pmin = 1000, d2_pmax = 0;
  int d2_rv_cyc = 0;
  logic [7:0] d2_rv_data = 8'h00;
  logic d2_done = 1'b0;
  logic d2_prev_sclk = 1'b0, d2_prev_csn = 1'b1, d2_prev_rv = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!d2_rst) begin
      if (!d2_spi_csn && d2_prev_csn) begin
        d2_low = 0; d2_word = '0; d2_last_rise = -1;
      end
      if (d2_spi_clk && !d2_prev_sclk) begin
        d2_word = {d2_word[22:0], d2_spi_mosi};
        if (d2_last_rise >= 0) begin
          if (cyc - d2_last_rise < d2_pmin) d2_pmin = cyc - d2_last_rise;
          if (cyc - d2_last_rise > d2_pmax) d2_pmax = cyc - d2_last_rise;
        end
        d2_last_rise = cyc;
      end
      if (d2_spi_csn && !d2_prev_csn) d2_width = d2_low;
      if (!d2_spi_csn) d2_low++;
      if (d2_rsp_valid && !d2_prev_rv) begin
        d2_rv_cyc = cyc; d2_rv_data = d2_rsp_rdata; d2_done = 1'b1;
      end
    end
    d2_prev_sclk = d2_spi_clk; d2_prev_csn = d2_spi_csn; d2_prev_rv = d2_rsp_valid;
  end

  int acc_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_cnt < n && k < 1000) begin tick(); k++; end
    `CHK("rsp_timeout", (rsp_cnt >= n), 1'b1)
  endtask

  // Present a command, wait for acceptance, optionally record the expected
  // response, then leave the bus scrambled (or valid held for queued traffic).
  task automatic send(input logic wr, input logic [9:0] a, input logic [7:0] d,
                      input logic [7:0] miso_b, input bit track, input bit keep_valid);
    int n = 0;
    logic [23:0] w;
    slave_byte = miso_b;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 2000) begin tick(); n++; end
    `CHK("accept_timeout", cmd_ready, 1'b1)
    acc_cyc = cyc;
    w = {wr, 5'b00000, a, (wr ? d : 8'h00)};
    if (track) exp_q.push_back('{word: w, rdata: (wr ? 8'h00 : miso_b), acc: cyc});
    tick();
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  initial begin
    int n, bad, edges0, base, t0;
    logic rv_seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    d2_rst = 1'b1; d2_cmd_valid = 1'b0; d2_cmd_write = 1'b0; d2_cmd_addr = '0;
    d2_cmd_wdata = '0; d2_rsp_ready = 1'b1; d2_spi_miso = 1'b1;
    repeat (3) tick();

    `CHK("rst_cmd_ready", cmd_ready, 1'b0)
    `CHK("rst_rsp_valid", rsp_valid, 1'b0)
    `CHK("rst_rsp_rdata", rsp_rdata, 8'h00)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_spi_csn", spi_csn, 1'b1)
    `CHK("rst_spi_clk", spi_clk, 1'b0)
    `CHK("rst_spi_mosi", spi_mosi, 1'b0)

    rst = 1'b0; d2_rst = 1'b0;
    tick();
    `CHK("cmd_ready_after_rst", cmd_ready, 1'b1)
    `CHK("busy_idle", busy, 1'b0)

    // Write, with a stray command offered while busy.
    send(1'b1, 10'h3F5, 8'hA5, 8'h00, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    repeat (100) tick();
    `CHK("busy_in_flight", busy, 1'b1)
    cmd_valid = 1'b0;
    wait_rsp(1);
    repeat (10) tick();
    `CHK("stray_cmd_ignored", txn_cnt, 1)

    // Read with chip returning 0x5C.
    send(1'b0, 10'h037, 8'hEE, 8'h5C, 1'b1, 1'b0);
    wait_rsp(2);

    // Response backpressure.
    rsp_ready = 1'b0;
    send(1'b0, 10'h037, 8'h00, 8'hC3, 1'b1, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin tick(); n++; end
    `CHK("bp_rsp_valid_seen", rsp_valid, 1'b1)
    bad = 0; edges0 = sclk_bad;
    repeat (20) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3 || cmd_ready !== 1'b0 ||
          spi_csn !== 1'b1 || busy !== 1'b1) bad++;
    end
    `CHK("bp_outputs_stable", bad, 0)
    `CHK("bp_no_sclk_edges", sclk_bad - edges0, 0)
    `CHK("bp_no_handshake", rsp_cnt, 2)
    rsp_ready = 1'b1;
    tick();
    `CHK("rsp_valid_clears", rsp_valid, 1'b0)
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    `CHK("cmd_ready_after_hs", (cyc - hs_cyc), P_GAP + 1)

    // Back-to-back queued writes.
    base = rsp_cnt; t0 = txn_cnt;
    send(1'b1, 10'h100, 8'h11, 8'h00, 1'b1, 1'b1);
    send(1'b1, 10'h2AA, 8'h22, 8'h00, 1'b1, 1'b1);
    send(1'b1, 10'h155, 8'h33, 8'h00, 1'b1, 1'b0);
    wait_rsp(base + 3);
    repeat (10) tick();
    `CHK("b2b_txn_count", (txn_cnt - t0), 3)
    `CHK("b2b_scoreboard_empty", exp_q.size(), 0)

    // Reset in the middle of a read's shift phase.
    base = rsp_cnt;
    send(1'b0, 10'h037, 8'h00, 8'h5C, 1'b0, 1'b0);
    while (cyc < acc_cyc + 100) tick();
    rst = 1'b1;
    tick();
    `CHK("midrst_spi_csn", spi_csn, 1'b1)
    `CHK("midrst_spi_clk", spi_clk, 1'b0)
    `CHK("midrst_spi_mosi", spi_mosi, 1'b0)
    `CHK("midrst_rsp_valid", rsp_valid, 1'b0)
    `CHK("midrst_busy", busy, 1'b0)
    `CHK("midrst_cmd_ready", cmd_ready, 1'b0)
    tick();
    rst = 1'b0;
    rv_seen = 1'b0;
    repeat (300) begin tick(); if (rsp_valid === 1'b1) rv_seen = 1'b1; end
    `CHK("midrst_no_response", rv_seen, 1'b0)
    `CHK("midrst_rsp_count", rsp_cnt, base)
    send(1'b1, 10'h2C4, 8'h5A, 8'h00, 1'b1, 1'b0);
    wait_rsp(base + 1);

    // Minimum-timing instance.
    d2_cmd_write = 1'b1; d2_cmd_addr = 10'h001; d2_cmd_wdata = 8'hFF; d2_cmd_valid = 1'b1;
    n = 0;
    while (d2_cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
    `CHK("d2_accept", d2_cmd_ready, 1'b1)
    acc_cyc = cyc;
    tick();
    d2_cmd_valid = 1'b0; d2_cmd_addr = 10'h3FF; d2_cmd_wdata = 8'h00;
    n = 0;
    while (d2_done !== 1'b1 && n < 200) begin tick(); n++; end
    `CHK("d2_rsp_seen", d2_done, 1'b1)
    `CHK("d2_mosi_word", d2_word, 24'h8001FF)
    `CHK("d2_csn_low_width", d2_width, 50)
    `CHK("d2_sclk_period_min", d2_pmin, 2)
    `CHK("d2_sclk_period_max", d2_pmax, 2)
    `CHK("d2_latency", (d2_rv_cyc - acc_cyc), 51)
    `CHK("d2_rdata", d2_rv_data, 8'h00)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
